// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result bus between a client and the shift sequencer
interface shift_sequencer_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
);
   logic             start;
   logic [6:0]       ctrl_in;
   logic [CNT_W-1:0] cnt_in;
   logic [WIDTH-1:0] data_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   modport master (output start, ctrl_in, cnt_in, data_in, input busy, done, result, carry_out);
   modport slave  (input start, ctrl_in, cnt_in, data_in, output busy, done, result, carry_out);
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: drives a single-step shifter N times, feeding its output back each cycle
module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   shift_sequencer_if.slave bus,
   output logic             sh_rin,
   output logic             sh_lin,
   output logic             sh_ain,
   output logic             sh_bin,
   output logic             sh_cin,
   output logic             sh_din,
   output logic             sh_ein,
   output logic             sh_shs,
   output logic [WIDTH-1:0] sh_a_bus,
   input  logic [WIDTH-1:0] sh_out,
   input  logic             sh_cf
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] work, work_nx, result_q;
   logic             carry, carry_nx, carry_out_q;
   logic [CNT_W-1:0] remaining;
   logic [6:0]       ctrl_q;
   logic             step;
   // A zero count passes once through SHIFT with the shifter disabled, so it
   // reaches DONE on the same edge a one-step operation would.
   assign step     = (state == SHIFT) && (remaining != '0);
   assign work_nx  = step ? sh_out : work;
   assign carry_nx = step ? sh_cf : carry;
   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   // Next-state logic; undefined encodings fall back to IDLE
   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:    state_nx = bus.start ? SHIFT : IDLE;
         SHIFT:   state_nx = (remaining > CNT_W'(1)) ? SHIFT : DONE;
         default: state_nx = IDLE;
      endcase
   end
   // Operand capture, per-step feedback, and result latch on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         work        <= '0;
         carry       <= 1'b0;
         remaining   <= '0;
         ctrl_q      <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         work      <= bus.data_in;
         ctrl_q    <= bus.ctrl_in;
         remaining <= bus.cnt_in;
         carry     <= 1'b0;
      end else if (state == SHIFT) begin
         work  <= work_nx;
         carry <= carry_nx;
         if (step) remaining <= remaining - CNT_W'(1);
         if (state_nx == DONE) begin
            result_q    <= work_nx;
            carry_out_q <= carry_nx;
         end
      end
   end
   assign sh_shs   = step;
   assign sh_a_bus = step ? work : '0;
   assign {sh_ein, sh_din, sh_cin, sh_bin, sh_ain, sh_lin, sh_rin} = step ? ctrl_q : 7'd0;
   assign bus.busy      = state != IDLE;
   assign bus.done      = state == DONE;
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
endmodule
